// File: rtl/fir_scie_pkg.sv
// Shared definitions for the complex-FIR SCIE sequencer.
// Holds the sizing parameters, the SCIE instruction encodings, the sequencer
// state enum, the complex sample type and a small index range helper.
package fir_scie_pkg;

    localparam int NTAPS = 3;   // number of FIR taps / coefficients
    localparam int DW    = 16;  // signed width of one real/imag component
    localparam int GAP   = 1;   // idle cycles between push and read
    localparam int IDXW  = 2;   // coefficient index width

    localparam logic [31:0] INSN_LOAD = 32'h0000000B;
    localparam logic [31:0] INSN_PUSH = 32'h0000002B;
    localparam logic [31:0] INSN_READ = 32'h0000005B;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PUSH = 3'd1,
        ST_WAIT = 3'd2,
        ST_READ = 3'd3,
        ST_CAPT = 3'd4
    } state_e;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    // True when a coefficient index addresses a real tap.
    function automatic logic idx_in_range(input logic [IDXW-1:0] idx);
        return (32'(idx) < 32'(NTAPS));
    endfunction

endpackage

// File: rtl/fir_scie_outbuf.sv
// One-entry valid/ready result register for the sequencer output stream.
// Ports:
//   clock, reset   : clock and asynchronous active-low reset
//   i_load, i_data : capture request and the result to hold
//   o_valid, o_data: buffered result, held stable until i_ready
//   i_ready        : downstream consumer ready
module fir_scie_outbuf
    import fir_scie_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  logic  i_load,
    input  cplx_t i_data,
    output logic  o_valid,
    output cplx_t o_data,
    input  logic  i_ready
);

    // Capture a result on load, release it once the consumer takes it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (i_load) begin
            o_valid <= 1'b1;
            o_data  <= i_data;
        end else if (o_valid && i_ready) begin
            o_valid <= 1'b0;
        end else begin
            o_valid <= o_valid;
        end
    end

endmodule

// File: rtl/fir_scie_sequencer.sv
// Sequencer driving the pipelined complex-FIR SCIE datapath for a stream client.
// Coefficient writes become LOAD instructions in the same cycle; each accepted
// sample becomes PUSH, a GAP-cycle wait, READ, then a capture of the datapath
// result into a one-entry output buffer.
// Ports:
//   clock, reset                         : clock, asynchronous active-low reset
//   coef_valid/ready, coef_idx/real/imag : coefficient write channel
//   in_valid/ready, in_real/imag         : sample input stream
//   out_valid/ready, out_real/imag       : result output stream
//   scie_valid, scie_insn, scie_rs1_*,
//   scie_rs2, scie_rd_*                  : SCIE datapath instruction port
//   loaded                               : every tap written since reset
//   err_idx                              : sticky out-of-range index flag
module fir_scie_sequencer
    import fir_scie_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 coef_valid,
    output logic                 coef_ready,
    input  logic [IDXW-1:0]      coef_idx,
    input  logic signed [DW-1:0] coef_real,
    input  logic signed [DW-1:0] coef_imag,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_real,
    input  logic signed [DW-1:0] in_imag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_real,
    output logic signed [DW-1:0] out_imag,
    output logic                 scie_valid,
    output logic [31:0]          scie_insn,
    output logic signed [DW-1:0] scie_rs1_real,
    output logic signed [DW-1:0] scie_rs1_imag,
    output logic [31:0]          scie_rs2,
    input  logic signed [DW-1:0] scie_rd_real,
    input  logic signed [DW-1:0] scie_rd_imag,
    output logic                 loaded,
    output logic                 err_idx
);

    localparam int              GCW      = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [GCW-1:0]  GAP_LAST = GCW'(GAP - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic             r_run;      // low during reset and its first clock after
    logic [GCW-1:0]   r_gap_cnt;
    logic [NTAPS-1:0] r_mask;
    logic             r_loaded;
    logic             r_err_idx;
    cplx_t            r_rs1;      // last operand 1 driven (or queued sample)
    logic [31:0]      r_rs2;

    logic             w_idle;
    logic             w_coef_fire;
    logic             w_in_fire;
    logic             w_load_issue;
    logic [NTAPS-1:0] w_mask_bit;
    cplx_t            w_coef;
    cplx_t            w_rd;
    cplx_t            w_out_data;
    logic             w_out_valid;

    assign w_idle       = (r_state == ST_IDLE);
    assign w_coef_fire  = coef_valid & coef_ready;
    assign w_in_fire    = in_valid & in_ready;
    assign w_load_issue = w_coef_fire & idx_in_range(coef_idx);
    assign w_mask_bit   = {{(NTAPS-1){1'b0}}, 1'b1} << coef_idx;
    assign w_coef       = '{re: coef_real, im: coef_imag};
    assign w_rd         = '{re: scie_rd_real, im: scie_rd_imag};

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> PUSH -> WAIT (GAP cycles) -> READ -> CAPT -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_in_fire) begin
                    w_state_nxt = ST_PUSH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PUSH: begin
                if (GAP == 0) begin
                    w_state_nxt = ST_READ;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = ST_READ;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_READ: w_state_nxt = ST_CAPT;
            ST_CAPT: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: handshakes and the SCIE instruction port.
    always_comb begin
        coef_ready = r_run & w_idle;
        // A coefficient write on the same cycle wins over a sample.
        in_ready   = r_run & w_idle & r_loaded & (~w_out_valid | out_ready) & ~coef_valid;
        scie_valid = 1'b0;
        scie_insn  = 32'h00000000;
        case (r_state)
            ST_IDLE: begin
                if (w_load_issue) begin
                    scie_valid = 1'b1;
                    scie_insn  = INSN_LOAD;
                end else begin
                    scie_valid = 1'b0;
                    scie_insn  = 32'h00000000;
                end
            end
            ST_PUSH: begin
                scie_valid = 1'b1;
                scie_insn  = INSN_PUSH;
            end
            ST_READ: begin
                scie_valid = 1'b1;
                scie_insn  = INSN_READ;
            end
            default: begin
                scie_valid = 1'b0;
                scie_insn  = 32'h00000000;
            end
        endcase
        // Operands are live for a LOAD, otherwise the last value is held.
        if (w_load_issue) begin
            scie_rs1_real = coef_real;
            scie_rs1_imag = coef_imag;
            scie_rs2      = {{(32-IDXW){1'b0}}, coef_idx};
        end else begin
            scie_rs1_real = r_rs1.re;
            scie_rs1_imag = r_rs1.im;
            scie_rs2      = r_rs2;
        end
    end

    // Run flag, wait counter, operand hold, coefficient mask and error flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_run     <= 1'b0;
            r_gap_cnt <= '0;
            r_rs1     <= '0;
            r_rs2     <= 32'h00000000;
            r_mask    <= '0;
            r_loaded  <= 1'b0;
            r_err_idx <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (r_state == ST_WAIT) begin
                r_gap_cnt <= r_gap_cnt + GCW'(1);
            end else begin
                r_gap_cnt <= '0;
            end
            if (w_load_issue) begin
                r_rs1    <= w_coef;
                r_rs2    <= {{(32-IDXW){1'b0}}, coef_idx};
                r_mask   <= r_mask | w_mask_bit;
                r_loaded <= &(r_mask | w_mask_bit);
            end else if (w_in_fire) begin
                r_rs1 <= '{re: in_real, im: in_imag};
            end else begin
                r_rs1 <= r_rs1;
            end
            if (w_coef_fire && !idx_in_range(coef_idx)) begin
                r_err_idx <= 1'b1;
            end else begin
                r_err_idx <= r_err_idx;
            end
        end
    end

    fir_scie_outbuf u_outbuf (
        .clock   (clock),
        .reset   (reset),
        .i_load  (r_state == ST_CAPT),
        .i_data  (w_rd),
        .o_valid (w_out_valid),
        .o_data  (w_out_data),
        .i_ready (out_ready)
    );

    assign out_valid = w_out_valid;
    assign out_real  = w_out_data.re;
    assign out_imag  = w_out_data.im;
    assign loaded    = r_loaded;
    assign err_idx   = r_err_idx;

endmodule
